// File: rtl/soil_rain_solar_adc_scanner.sv
// soil_rain_solar_adc_scanner
// Scans the soil, rain and solar channels of an ADC128S022-style SPI ADC.
// Each channel is averaged over 2^AVG_LOG2 conversions. The three 8-bit
// means are published together as {solar, rain, soil} with a one-cycle
// data_valid strobe.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for enable; chip select high, SCLK idle high
// START | chip select low, SCLK high for one half-period before bit 15
// SHIFT | 16 SCLK periods: drive DIN on the fall, sample DOUT on the rise
// STORE | chip select high for one half-period; frame result accumulated
// GAP   | inter-scan idle time, then rescan or fall back to IDLE
//
// The ADC answers one frame late: the address sent in frame k selects
// the conversion returned in frame k+1. A scan is therefore 3N+1 frames.
// Frame 0's returned data is junk, and frame 3N carries a dummy address.

module soil_rain_solar_adc_scanner #(
    parameter int CLK_DIV  = 25,
    parameter int AVG_LOG2 = 2,
    parameter int SOIL_CH  = 0,
    parameter int RAIN_CH  = 1,
    parameter int SOLAR_CH = 2,
    parameter int SCAN_GAP = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [23:0] data_out,
    output logic        data_valid,
    output logic        busy
);

    localparam int N_CONV = 3 << AVG_LOG2;
    localparam int FW     = $clog2(N_CONV + 1);
    localparam int AW     = 12 + AVG_LOG2;
    localparam int GW     = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    localparam logic [7:0]    DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(SCAN_GAP - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(N_CONV);
    localparam logic [2:0]    SOIL_A     = 3'(SOIL_CH);
    localparam logic [2:0]    RAIN_A     = 3'(RAIN_CH);
    localparam logic [2:0]    SOLAR_A    = 3'(SOLAR_CH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        STORE,
        GAP
    } state_t;

    state_t          state;
    logic [7:0]      div_cnt;
    logic [3:0]      bit_cnt;
    logic [FW-1:0]   frame_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [15:0]     tx_sh;
    logic [11:0]     rx_sh;
    logic [AW-1:0]   acc_soil;
    logic [AW-1:0]   acc_rain;
    logic [AW-1:0]   acc_solar;

    // Channel group of a conversion index: 0 soil, 1 rain, 2 solar.
    function automatic logic [1:0] group_of(input logic [FW-1:0] conv);
        return 2'(conv >> AVG_LOG2);
    endfunction

    // DIN word sent in a given frame; the trailing frame carries soil as a dummy.
    function automatic logic [15:0] din_word(input logic [FW-1:0] frame);
        logic [2:0] addr;
        if (frame >= LAST_FRAME) begin
            addr = SOIL_A;
        end else begin
            case (group_of(frame))
                2'd0:    addr = SOIL_A;
                2'd1:    addr = RAIN_A;
                default: addr = SOLAR_A;
            endcase
        end
        return {2'b00, addr, 11'b0};
    endfunction

    // Scan sequencer: SPI framing, accumulation and atomic publish.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b1;
            adc_din    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            frame_cnt  <= '0;
            gap_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            acc_soil   <= '0;
            acc_rain   <= '0;
            acc_solar  <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= START;
                        busy      <= 1'b1;
                        adc_cs_n  <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        frame_cnt <= '0;
                        tx_sh     <= din_word('0);
                        acc_soil  <= '0;
                        acc_rain  <= '0;
                        acc_solar <= '0;
                    end
                end

                START: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        state    <= SHIFT;
                        adc_sclk <= 1'b0;
                        adc_din  <= tx_sh[15];
                        tx_sh    <= {tx_sh[14:0], 1'b0};
                        bit_cnt  <= '0;
                        div_cnt  <= DIV_LOAD;
                    end
                end

                SHIFT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (!adc_sclk) begin
                            // Rising SCLK: capture DOUT; only the low 12 bits survive.
                            adc_sclk <= 1'b1;
                            rx_sh    <= {rx_sh[10:0], adc_dout};
                        end else if (bit_cnt == 4'd15) begin
                            // Frame done; rx_sh has been complete since the last rise.
                            adc_cs_n <= 1'b1;
                            state    <= STORE;
                            if (frame_cnt != '0) begin
                                case (group_of(frame_cnt - FW'(1)))
                                    2'd0:    acc_soil  <= acc_soil  + AW'(rx_sh);
                                    2'd1:    acc_rain  <= acc_rain  + AW'(rx_sh);
                                    default: acc_solar <= acc_solar + AW'(rx_sh);
                                endcase
                            end
                        end else begin
                            adc_sclk <= 1'b0;
                            adc_din  <= tx_sh[15];
                            tx_sh    <= {tx_sh[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                end

                STORE: begin
                    // Publish on the first STORE cycle of the last frame, one clk after CS rises.
                    if (div_cnt == DIV_LOAD && frame_cnt == LAST_FRAME) begin
                        data_out   <= {acc_solar[AW-1 -: 8], acc_rain[AW-1 -: 8],
                                       acc_soil[AW-1 -: 8]};
                        data_valid <= 1'b1;
                        busy       <= 1'b0;
                    end
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (frame_cnt == LAST_FRAME) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state     <= START;
                        adc_cs_n  <= 1'b0;
                        frame_cnt <= frame_cnt + FW'(1);
                        tx_sh     <= din_word(frame_cnt + FW'(1));
                        div_cnt   <= DIV_LOAD;
                    end
                end

                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (enable) begin
                        state     <= START;
                        busy      <= 1'b1;
                        adc_cs_n  <= 1'b0;
                        div_cnt   <= DIV_LOAD;
                        frame_cnt <= '0;
                        tx_sh     <= din_word('0);
                        acc_soil  <= '0;
                        acc_rain  <= '0;
                        acc_solar <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soil_rain_solar_adc_scanner.sv
// Testbench for soil_rain_solar_adc_scanner: an ADC model feeds per-frame
// values; expected words are queued per scan and checked on data_valid.
`timescale 1ns/1ps

module tb_soil_rain_solar_adc_scanner;

    localparam int CLK_DIV  = 4;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;
    localparam int NF       = 3 * N + 1;
    localparam int SCAN_GAP = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        adc_cs_n, adc_sclk, adc_din;
    logic        adc_dout = 1'b0;
    logic [23:0] data_out;
    logic        data_valid, busy;

    logic        enable_b = 1'b0;
    logic        adc_cs_n_b, adc_sclk_b, adc_din_b;
    logic        adc_dout_b = 1'b0;
    logic [23:0] data_out_b;
    logic        data_valid_b, busy_b;

    always #5 clk = ~clk;

    soil_rain_solar_adc_scanner #(
        .CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2), .SOIL_CH(0), .RAIN_CH(1),
        .SOLAR_CH(2), .SCAN_GAP(SCAN_GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
        .adc_dout(adc_dout), .data_out(data_out), .data_valid(data_valid),
        .busy(busy)
    );

    soil_rain_solar_adc_scanner #(
        .CLK_DIV(3), .AVG_LOG2(0), .SOIL_CH(0), .RAIN_CH(1),
        .SOLAR_CH(2), .SCAN_GAP(5)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b),
        .adc_cs_n(adc_cs_n_b), .adc_sclk(adc_sclk_b), .adc_din(adc_din_b),
        .adc_dout(adc_dout_b), .data_out(data_out_b), .data_valid(data_valid_b),
        .busy(busy_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // ---------------- reference model + ADC model for dut ----------------
    logic [23:0] exp_q[$];
    logic [11:0] vals[NF];
    logic [11:0] force_vals[NF];
    bit          force_pending = 1'b0;
    int          fi = 0;
    int          cyc = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
    logic [15:0] word = '0;
    logic [15:0] din_sh = '0;
    int          bitn = 0, cs_low_cnt = 0, cs_high_cnt = 0;
    int          fall_cnt = 0, last_fall = 0, fall_bad = 0;
    int          viol_sclk = 0, viol_din = 0;

    // Expected word: top 8 bits of each channel's integer mean.
    function automatic logic [23:0] ref_word();
        logic [23:0] w;
        int          sum;
        w = '0;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int i = 0; i < N; i++) sum += int'(vals[1 + ch * N + i]);
            w = w | (24'(((sum / N) >> 4) & 255) << (8 * ch));
        end
        return w;
    endfunction

    // Channel the DUT must address in frame f (channels 0/1/2, trailing dummy is soil).
    function automatic logic [15:0] exp_din(input int f);
        int a;
        a = (f < 3 * N) ? (f / N) : 0;
        return 16'(a << 11);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            fi = 0; prev_cs = 1'b1; prev_sclk = 1'b1; prev_din = 1'b0;
            adc_dout = 1'b0; bitn = 0; cs_low_cnt = 0; cs_high_cnt = 0;
            exp_q.delete();
        end else begin
            if (adc_cs_n && !adc_sclk) viol_sclk++;
            if (adc_din != prev_din && !(prev_sclk && !adc_sclk)) viol_din++;
            if (prev_cs && !adc_cs_n) begin
                if (fi != 0) check("cs_high_between_frames", cs_high_cnt, CLK_DIV);
                if (fi == 0) begin
                    if (force_pending) begin
                        vals = force_vals;
                        force_pending = 1'b0;
                    end else begin
                        for (int k = 0; k < NF; k++) vals[k] = 12'($urandom_range(0, 4095));
                    end
                    exp_q.push_back(ref_word());
                end
                word = {4'($urandom_range(0, 15)), vals[fi]};
                bitn = 0; fall_cnt = 0; fall_bad = 0; cs_low_cnt = 0; din_sh = '0;
            end
            if (!prev_cs && adc_cs_n) begin
                check("cs_low_cycles", cs_low_cnt, 33 * CLK_DIV);
                check("sclk_falls_per_frame", fall_cnt, 16);
                check("sclk_period_bad", fall_bad, 0);
                check("din_frame_word", din_sh, exp_din(fi));
                fi = (fi == NF - 1) ? 0 : fi + 1;
                cs_high_cnt = 0;
            end
            if (!adc_cs_n) cs_low_cnt++; else cs_high_cnt++;
            if (!adc_cs_n && prev_sclk && !adc_sclk) begin
                if (fall_cnt > 0 && cyc - last_fall != 2 * CLK_DIV) fall_bad++;
                last_fall = cyc;
                fall_cnt++;
                if (bitn < 16) begin
                    adc_dout = word[15 - bitn];
                    bitn++;
                end
            end
            if (!adc_cs_n && !prev_sclk && adc_sclk) din_sh = {din_sh[14:0], adc_din};
            prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_din = adc_din;
        end
    end

    // Scoreboard monitor: pop and compare whenever the DUT publishes.
    always @(negedge clk) begin
        logic [23:0] e;
        if (reset_n && data_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL scoreboard_unexpected: got data_out 0x%0h, required no pulse", data_out);
            end else begin
                e = exp_q.pop_front();
                check("scan_result", data_out, e);
            end
            check("busy_low_at_valid", busy, 0);
        end
    end

    // ---------------- AVG_LOG2=0 instance: fixed per-frame values ----------------
    int          fb = 0, bb = 0, b_dv_cnt = 0;
    logic        pcs_b = 1'b1, psclk_b = 1'b1;
    logic [15:0] word_b = '0;

    function automatic logic [11:0] val_b(input int f);
        case (f)
            0:       return 12'h3C7;
            1:       return 12'hABC;
            2:       return 12'h555;
            default: return 12'h0F0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            fb = 0; bb = 0; pcs_b = 1'b1; psclk_b = 1'b1; adc_dout_b = 1'b0;
        end else begin
            if (pcs_b && !adc_cs_n_b) begin
                word_b = {4'h5, val_b(fb)};
                bb = 0;
            end
            if (!pcs_b && adc_cs_n_b) fb = (fb == 3) ? 0 : fb + 1;
            if (!adc_cs_n_b && psclk_b && !adc_sclk_b && bb < 16) begin
                adc_dout_b = word_b[15 - bb];
                bb++;
            end
            if (data_valid_b) begin
                b_dv_cnt++;
                check("single_sample_result", data_out_b, 24'h0F55AB);
            end
            pcs_b = adc_cs_n_b; psclk_b = adc_sclk_b;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_dv(input string nm, output int t);
        int k;
        k = 0;
        @(negedge clk);
        while (!data_valid && k < 4000) begin
            @(negedge clk);
            k++;
        end
        t = int'($time / 10);
        if (!data_valid) begin
            n_cmp++; n_err++;
            $display("FAIL %s: got no data_valid, required one within 4000 cycles", nm);
        end
    endtask

    task automatic wait_frame(input int idx);
        int k;
        k = 0;
        while (!(fi == idx && !adc_cs_n) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) begin
            n_cmp++; n_err++;
            $display("FAIL wait_frame_%0d: got timeout, required frame reached", idx);
        end
    endtask

    task automatic load_const();
        force_vals[0] = 12'h7A5;
        for (int i = 0; i < N; i++) begin
            force_vals[1 + i]         = 12'h123;
            force_vals[1 + N + i]     = 12'h800;
            force_vals[1 + 2 * N + i] = 12'hFFF;
        end
        force_pending = 1'b1;
    endtask

    initial begin
        int t1, t2, t3, t4, t5, p1, cs_seen, dv_seen;

        repeat (3) @(negedge clk);
        check("reset_cs_n", adc_cs_n, 1);
        check("reset_sclk", adc_sclk, 1);
        check("reset_din", adc_din, 0);
        check("reset_data_out", data_out, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        enable_b = 1'b1;
        repeat (2) @(negedge clk);

        // constant inputs
        load_const();
        enable = 1'b1;
        wait_dv("const_scan", t1);
        check("const_data_out", data_out, 24'hFF8012);
        // averaging plus junk in frame 0
        force_vals[0] = 12'hFFF;
        for (int i = 1; i < NF; i++) force_vals[i] = 12'h000;
        for (int i = 0; i < N; i++) force_vals[1 + i] = 12'(256 * (i + 1));
        force_pending = 1'b1;
        @(negedge clk);
        check("busy_after_valid", busy, 0);
        wait_dv("avg_scan", t2);
        check("avg_data_out", data_out, 24'h000028);
        // random back-to-back scans and period
        wait_dv("rand_scan1", t3);
        wait_dv("rand_scan2", t4);
        wait_dv("rand_scan3", t5);
        p1 = t2 - t1;
        check("period_near_nominal",
              ((p1 - (NF * 34 * CLK_DIV + SCAN_GAP + 1)) <= 1 &&
               (p1 - (NF * 34 * CLK_DIV + SCAN_GAP + 1)) >= -1), 1);
        check("period_const_2", t3 - t2, p1);
        check("period_const_3", t4 - t3, p1);
        check("period_const_4", t5 - t4, p1);

        // enable drop during frame 5
        wait_frame(5);
        enable = 1'b0;
        wait_dv("drop_scan", t1);
        cs_seen = 0;
        dv_seen = 0;
        repeat (SCAN_GAP + 300) begin
            @(negedge clk);
            if (!adc_cs_n) cs_seen++;
            if (data_valid) dv_seen++;
        end
        check("idle_no_cs_activity", cs_seen, 0);
        check("idle_no_extra_valid", dv_seen, 0);
        check("idle_busy", busy, 0);

        // re-enable starts at frame 0
        enable = 1'b1;
        cs_seen = 0;
        while (adc_cs_n && cs_seen < 100) begin
            @(negedge clk);
            cs_seen++;
        end
        check("reenable_cs_low", adc_cs_n, 0);
        check("reenable_frame0", fi, 0);
        wait_dv("reenable_scan", t1);

        // reset mid-frame 7
        wait_frame(7);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        load_const();
        reset_n = 1'b1;
        wait_dv("post_reset_scan", t1);
        check("post_reset_data_out", data_out, 24'hFF8012);
        enable = 1'b0;
        repeat (SCAN_GAP + 100) @(negedge clk);

        check("sclk_high_while_cs_high", viol_sclk, 0);
        check("din_changes_on_fall_only", viol_din, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("single_sample_pulses_seen", (b_dv_cnt > 0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
